// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter_if
// Brief    : Requester-side request/acknowledge bundle for dmem_port_arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input  ack, rdata, err);
  modport slave  (input  req, we, addr, wdata, output ack, rdata, err);
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Round-robin CPU/debugger sharing of a single-ported data memory.
//            Optional macro DMEM_ADDR_CHECK_EN traps addresses >= DEPTH.
// Revision : 1.0
// ============================================================================
module dmem_port_arbiter #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  dmem_port_arbiter_if.slave cpu,
  dmem_port_arbiter_if.slave dbg,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_read,
  output logic               mem_write_en,
  output logic               mem_write,
  input  logic [31:0]        mem_rdata,
  output logic               busy,
  output logic [CNT_W-1:0]   txn_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ARM   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic c_CPU = 1'b0;
  localparam logic c_DBG = 1'b1;
`ifdef DMEM_ADDR_CHECK_EN
  localparam bit c_CHECK_EN = 1'b1;
`else
  localparam bit c_CHECK_EN = 1'b0;
`endif

  state_t           r_state, w_next;
  logic             r_owner, r_last;
  logic             w_take, w_gnt_dbg, w_gnt_we, w_aerr, w_owner_nxt;
  logic [31:0]      w_gnt_addr, w_gnt_wdata, w_done_data;
  logic [31:0]      r_mem_addr, r_mem_wdata, r_cpu_rdata, r_dbg_rdata;
  logic             r_mem_read, r_mem_write_en, r_mem_write, r_busy;
  logic             r_cpu_ack, r_dbg_ack;
  logic [CNT_W-1:0] r_txn;

  // DBG wins a tie only when the CPU held the previous grant.
  always_comb begin
    w_take      = (r_state == S_IDLE) && (cpu.req || dbg.req);
    w_gnt_dbg   = dbg.req && (!cpu.req || (r_last == c_CPU));
    w_gnt_we    = w_gnt_dbg ? dbg.we    : cpu.we;
    w_gnt_addr  = w_gnt_dbg ? dbg.addr  : cpu.addr;
    w_gnt_wdata = w_gnt_dbg ? dbg.wdata : cpu.wdata;
    w_aerr      = c_CHECK_EN && (w_gnt_addr >= 32'(DEPTH));
    w_owner_nxt = w_take ? w_gnt_dbg : r_owner;
    w_done_data = (r_state == S_READ) ? mem_rdata : 32'd0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          if (w_aerr)        w_next = S_DONE;
          else if (w_gnt_we) w_next = S_ARM;
          else               w_next = S_READ;
        end
      end
      S_READ:  w_next = S_DONE;
      S_ARM:   w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Outputs are decoded from the next state so each strobe is a clean register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_owner        <= c_CPU;
      r_last         <= c_DBG;
      r_mem_addr     <= 32'd0;
      r_mem_wdata    <= 32'd0;
      r_mem_read     <= 1'b0;
      r_mem_write_en <= 1'b0;
      r_mem_write    <= 1'b0;
      r_busy         <= 1'b0;
      r_cpu_ack      <= 1'b0;
      r_dbg_ack      <= 1'b0;
      r_cpu_rdata    <= 32'd0;
      r_dbg_rdata    <= 32'd0;
      r_txn          <= '0;
    end else begin
      r_mem_read     <= (w_next == S_READ);
      r_mem_write_en <= (w_next == S_ARM);
      r_mem_write    <= (w_next == S_WRITE);
      r_busy         <= (w_next != S_IDLE);
      r_cpu_ack      <= (w_next == S_DONE) && (w_owner_nxt == c_CPU);
      r_dbg_ack      <= (w_next == S_DONE) && (w_owner_nxt == c_DBG);
      if (w_take) begin
        r_owner     <= w_gnt_dbg;
        r_last      <= w_gnt_dbg;
        r_mem_addr  <= w_gnt_addr;
        r_mem_wdata <= w_gnt_wdata;
      end
      if (w_next == S_DONE) begin
        r_txn <= r_txn + CNT_W'(1);
        if (w_owner_nxt == c_DBG) r_dbg_rdata <= w_done_data;
        else                      r_cpu_rdata <= w_done_data;
      end
    end
  end

`ifdef DMEM_ADDR_CHECK_EN
  logic r_cpu_err, r_dbg_err;

  // Entering DONE straight from IDLE only happens for an out-of-range grant.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cpu_err <= 1'b0;
      r_dbg_err <= 1'b0;
    end else if (w_next == S_DONE) begin
      if (w_owner_nxt == c_DBG) r_dbg_err <= w_take;
      else                      r_cpu_err <= w_take;
    end
  end

  assign cpu.err = r_cpu_err;
  assign dbg.err = r_dbg_err;
`else
  assign cpu.err = 1'b0;
  assign dbg.err = 1'b0;
`endif

  assign cpu.ack      = r_cpu_ack;
  assign cpu.rdata    = r_cpu_rdata;
  assign dbg.ack      = r_dbg_ack;
  assign dbg.rdata    = r_dbg_rdata;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_read     = r_mem_read;
  assign mem_write_en = r_mem_write_en;
  assign mem_write    = r_mem_write;
  assign busy         = r_busy;
  assign txn_count    = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Directed self-checking bench for dmem_port_arbiter (CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_dmem_port_arbiter;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write_en, mem_write, busy;
  logic [3:0]  txn_count;
  logic [31:0] mem [0:127];
  logic        mem_ready = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  exp_txn = 4'd0;

  dmem_port_arbiter_if cpu ();
  dmem_port_arbiter_if dbg ();

  dmem_port_arbiter #(.DEPTH(128), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .cpu(cpu), .dbg(dbg),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write_en(mem_write_en), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 Clk = ~Clk;

  // Memory model: word i holds i until written.
  assign mem_rdata = mem[mem_addr[6:0]];
  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'(i);
    end else if (mem_write) begin
      mem[mem_addr[6:0]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #1 Rst = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (txn_count !== 4'd0) begin n_err++; $display("FAIL reset_txn: got %0d want 0", txn_count); end
    n_vec++; if ({mem_read, mem_write_en, mem_write} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {mem_read, mem_write_en, mem_write}); end
    n_vec++; if (mem_addr !== 32'd0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_vec++; if ({cpu.ack, dbg.ack, cpu.err, dbg.err} !== 4'b0000) begin n_err++; $display("FAIL reset_ack_err: got %b want 0000", {cpu.ack, dbg.ack, cpu.err, dbg.err}); end
    n_vec++; if (cpu.rdata !== 32'd0) begin n_err++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu.rdata); end
    tick();
    mem_ready = 1'b1;
    tick();
    Rst = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_cpu_read();
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 32'd5;
    tick();
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rd_mem_read: got %b want 1", mem_read); end
    n_vec++; if (mem_addr !== 32'd5) begin n_err++; $display("FAIL rd_mem_addr: got %h want 5", mem_addr); end
    n_vec++; if (cpu.ack !== 1'b0) begin n_err++; $display("FAIL rd_early_ack: got %b want 0", cpu.ack); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy: got %b want 1", busy); end
    tick();
    exp_txn++;
    n_vec++; if (cpu.ack !== 1'b1) begin n_err++; $display("FAIL rd_ack: got %b want 1", cpu.ack); end
    n_vec++; if (cpu.rdata !== 32'd5) begin n_err++; $display("FAIL rd_rdata: got %h want 5", cpu.rdata); end
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rd_read_len: got %b want 0", mem_read); end
    n_vec++; if (txn_count !== exp_txn) begin n_err++; $display("FAIL rd_txn: got %0d want %0d", txn_count, exp_txn); end
    n_vec++; if ({dbg.ack, cpu.err} !== 2'b00) begin n_err++; $display("FAIL rd_dbg_ack_err: got %b want 00", {dbg.ack, cpu.err}); end
    cpu.req = 1'b0;
    tick();
    n_vec++; if ({cpu.ack, busy} !== 2'b00) begin n_err++; $display("FAIL rd_after: got %b want 00", {cpu.ack, busy}); end
  endtask

  task automatic test_cpu_write();
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 32'd10; cpu.wdata = 32'hDEADBEEF;
    tick();
    n_vec++; if ({mem_read, mem_write_en, mem_write} !== 3'b010) begin n_err++; $display("FAIL wr_arm: got %b want 010", {mem_read, mem_write_en, mem_write}); end
    tick();
    n_vec++; if ({mem_read, mem_write_en, mem_write} !== 3'b001) begin n_err++; $display("FAIL wr_write: got %b want 001", {mem_read, mem_write_en, mem_write}); end
    n_vec++; if (mem_addr !== 32'd10) begin n_err++; $display("FAIL wr_addr: got %h want a", mem_addr); end
    n_vec++; if (mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata); end
    n_vec++; if (cpu.ack !== 1'b0) begin n_err++; $display("FAIL wr_early_ack: got %b want 0", cpu.ack); end
    tick();
    exp_txn++;
    n_vec++; if (cpu.ack !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b want 1", cpu.ack); end
    n_vec++; if (cpu.rdata !== 32'd0) begin n_err++; $display("FAIL wr_rdata: got %h want 0", cpu.rdata); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL wr_write_len: got %b want 0", mem_write); end
    n_vec++; if (txn_count !== exp_txn) begin n_err++; $display("FAIL wr_txn: got %0d want %0d", txn_count, exp_txn); end
    cpu.req = 1'b0; cpu.we = 1'b0;
    tick();
    dbg.req = 1'b1; dbg.we = 1'b0; dbg.addr = 32'd10;
    tick();
    tick();
    exp_txn++;
    n_vec++; if (dbg.ack !== 1'b1) begin n_err++; $display("FAIL wr_rb_ack: got %b want 1", dbg.ack); end
    n_vec++; if (dbg.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rb_rdata: got %h want deadbeef", dbg.rdata); end
    n_vec++; if (cpu.rdata !== 32'd0) begin n_err++; $display("FAIL wr_rb_cpu_hold: got %h want 0", cpu.rdata); end
    n_vec++; if (txn_count !== exp_txn) begin n_err++; $display("FAIL wr_rb_txn: got %0d want %0d", txn_count, exp_txn); end
    dbg.req = 1'b0;
    tick();
  endtask

  task automatic test_arbitration();
    logic exp_dbg;
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 32'd1;
    dbg.req = 1'b1; dbg.we = 1'b0; dbg.addr = 32'd2;
    for (int k = 0; k < 4; k++) begin
      exp_dbg = (k % 2) == 1;
      tick();
      n_vec++; if (mem_addr !== (exp_dbg ? 32'd2 : 32'd1)) begin n_err++; $display("FAIL arb_addr[%0d]: got %h want %h", k, mem_addr, exp_dbg ? 32'd2 : 32'd1); end
      tick();
      exp_txn++;
      n_vec++; if ({cpu.ack, dbg.ack} !== {~exp_dbg, exp_dbg}) begin n_err++; $display("FAIL arb_ack[%0d]: got %b want %b", k, {cpu.ack, dbg.ack}, {~exp_dbg, exp_dbg}); end
      n_vec++; if ((exp_dbg ? dbg.rdata : cpu.rdata) !== (exp_dbg ? 32'd2 : 32'd1)) begin n_err++; $display("FAIL arb_rdata[%0d]: got %h want %h", k, exp_dbg ? dbg.rdata : cpu.rdata, exp_dbg ? 32'd2 : 32'd1); end
      if (k == 3) begin cpu.req = 1'b0; dbg.req = 1'b0; end
      tick();
      n_vec++; if ({cpu.ack, dbg.ack} !== 2'b00) begin n_err++; $display("FAIL arb_ack_pulse[%0d]: got %b want 00", k, {cpu.ack, dbg.ack}); end
    end
    n_vec++; if (txn_count !== exp_txn) begin n_err++; $display("FAIL arb_txn: got %0d want %0d", txn_count, exp_txn); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arb_idle: got %b want 0", busy); end
  endtask

  task automatic test_req_drop();
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 32'd3;
    tick();
    cpu.req = 1'b0;
    tick();
    exp_txn++;
    n_vec++; if (cpu.ack !== 1'b1) begin n_err++; $display("FAIL drop_ack: got %b want 1", cpu.ack); end
    n_vec++; if (cpu.rdata !== 32'd3) begin n_err++; $display("FAIL drop_rdata: got %h want 3", cpu.rdata); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_write();
    logic saw_write;
    saw_write = 1'b0;
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 32'd20; cpu.wdata = 32'h12345678;
    tick();
    n_vec++; if (mem_write_en !== 1'b1) begin n_err++; $display("FAIL rst_arm: got %b want 1", mem_write_en); end
    #2 Rst = 1'b0;
    #1;
    cpu.req = 1'b0; cpu.we = 1'b0;
    exp_txn = 4'd0;
    n_vec++; if ({busy, mem_write_en, mem_write} !== 3'b000) begin n_err++; $display("FAIL rst_strobes: got %b want 000", {busy, mem_write_en, mem_write}); end
    n_vec++; if (mem_addr !== 32'd0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_vec++; if (txn_count !== 4'd0) begin n_err++; $display("FAIL rst_txn: got %0d want 0", txn_count); end
    n_vec++; if (dbg.rdata !== 32'd0) begin n_err++; $display("FAIL rst_dbg_rdata: got %h want 0", dbg.rdata); end
    repeat (2) begin
      tick();
      if (mem_write) saw_write = 1'b1;
    end
    Rst = 1'b1;
    tick();
    n_vec++; if (saw_write !== 1'b0) begin n_err++; $display("FAIL rst_no_write: got %b want 0", saw_write); end
    dbg.req = 1'b1; dbg.we = 1'b0; dbg.addr = 32'd20;
    tick();
    tick();
    exp_txn++;
    n_vec++; if (dbg.ack !== 1'b1) begin n_err++; $display("FAIL rst_rb_ack: got %b want 1", dbg.ack); end
    n_vec++; if (dbg.rdata !== 32'd20) begin n_err++; $display("FAIL rst_rb_word20: got %h want 14", dbg.rdata); end
    n_vec++; if (txn_count !== exp_txn) begin n_err++; $display("FAIL rst_rb_txn: got %0d want %0d", txn_count, exp_txn); end
    dbg.req = 1'b0;
    tick();
  endtask

  task automatic test_addr_check();
    dbg.req = 1'b1; dbg.we = 1'b0; dbg.addr = 32'd128;
`ifdef DMEM_ADDR_CHECK_EN
    tick();
    exp_txn++;
    n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL oob_no_read: got %b want 0", mem_read); end
    n_vec++; if ({dbg.ack, dbg.err} !== 2'b11) begin n_err++; $display("FAIL oob_ack_err: got %b want 11", {dbg.ack, dbg.err}); end
    n_vec++; if (dbg.rdata !== 32'd0) begin n_err++; $display("FAIL oob_rdata: got %h want 0", dbg.rdata); end
    n_vec++; if (txn_count !== exp_txn) begin n_err++; $display("FAIL oob_txn: got %0d want %0d", txn_count, exp_txn); end
`else
    tick();
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL oob_read: got %b want 1", mem_read); end
    n_vec++; if (mem_addr !== 32'd128) begin n_err++; $display("FAIL oob_addr: got %h want 80", mem_addr); end
    tick();
    exp_txn++;
    n_vec++; if ({dbg.ack, dbg.err} !== 2'b10) begin n_err++; $display("FAIL oob_ack_err: got %b want 10", {dbg.ack, dbg.err}); end
    n_vec++; if (dbg.rdata !== 32'd0) begin n_err++; $display("FAIL oob_rdata: got %h want 0", dbg.rdata); end
    n_vec++; if (txn_count !== exp_txn) begin n_err++; $display("FAIL oob_txn: got %0d want %0d", txn_count, exp_txn); end
`endif
    dbg.req = 1'b0;
    tick();
    n_vec++; if (dbg.ack !== 1'b0) begin n_err++; $display("FAIL oob_ack_pulse: got %b want 0", dbg.ack); end
  endtask

  task automatic test_txn_wrap();
    cpu.we = 1'b0; cpu.addr = 32'd7;
    while (exp_txn != 4'd15) begin
      cpu.req = 1'b1;
      tick();
      tick();
      exp_txn++;
      cpu.req = 1'b0;
      tick();
    end
    n_vec++; if (txn_count !== 4'd15) begin n_err++; $display("FAIL wrap_pre: got %0d want 15", txn_count); end
    cpu.req = 1'b1;
    tick();
    tick();
    exp_txn++;
    n_vec++; if (cpu.ack !== 1'b1) begin n_err++; $display("FAIL wrap_ack: got %b want 1", cpu.ack); end
    n_vec++; if (txn_count !== 4'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", txn_count); end
    cpu.req = 1'b0;
    tick();
    n_vec++; if (txn_count !== 4'd0) begin n_err++; $display("FAIL wrap_hold: got %0d want 0", txn_count); end
  endtask

  initial begin
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = 32'd0; cpu.wdata = 32'd0;
    dbg.req = 1'b0; dbg.we = 1'b0; dbg.addr = 32'd0; dbg.wdata = 32'd0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_arbitration();
    test_req_drop();
    test_reset_mid_write();
    test_addr_check();
    test_txn_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the processor load/store port (CPU) and the board debugger (DBG).
- Arbitrates round-robin and sequences each access into the memory's control signals: read strobe, write-arm strobe, then write strobe.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Keeps a wrapping count of completed transactions for the debugger display.

Parameters:
- DEPTH, 128, number of 32-bit words in the attached memory; valid addresses are 0..DEPTH-1.
- CNT_W, 16, width of the transaction counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; held high with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  word address.
- cpu_wdata  in  32  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read result, valid when cpu_ack=1.
- cpu_err  out  1  address-error flag, valid with cpu_ack.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata, dbg_err  same directions/widths/meaning for DBG.
- mem_addr  out  32  address to memory.
- mem_wdata  out  32  write data to memory.
- mem_read  out  1  read strobe.
- mem_write_en  out  1  write-arm pulse; moves memory into its write state.
- mem_write  out  1  write strobe; memory commits at this cycle's edge.
- mem_rdata  in  32  combinational read data from memory.
- busy  out  1  high in any state other than IDLE.
- txn_count  out  CNT_W  completed transactions, wraps to 0.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; last_grant=DBG, so CPU wins the first tie.
- All outputs 0 on reset: acks, errs, rdata, mem_*, busy, txn_count.
- States: IDLE, READ, ARM, WRITE, DONE. All outputs are registered.
- IDLE:
  - Sample requests. If both are high, grant the requester not equal to last_grant; otherwise grant the single requester.
  - On grant: latch owner, we, addr, wdata; update last_grant; go to READ if we=0, else ARM.
  - No request: stay IDLE.
- READ: mem_read=1, mem_addr=latched addr. Capture mem_rdata into the owner's rdata at the edge. Go to DONE.
- ARM: mem_write_en=1 for exactly one cycle. Go to WRITE.
- WRITE: mem_write=1 with mem_addr/mem_wdata = latched values. Go to DONE.
- DONE:
  - Owner's ack=1 for one cycle; txn_count += 1 (mod 2^CNT_W). Go to IDLE.
  - For writes, the owner's rdata is set to 0.
- Latency from req sampled in IDLE to ack: read = 2 cycles, write = 3 cycles.
- Back-to-back: ack is followed by a mandatory IDLE cycle, giving a throughput of 1 access per 3 (read) or 4 (write) cycles.
- A req still high in the IDLE cycle after its ack is a new request.
- Requests arriving while busy wait; nothing is queued beyond the level-held req.
- Non-owner ack/rdata/err stay unchanged (rdata holds its last value).
- mem_addr/mem_wdata hold their latched values between transactions. mem_read/mem_write_en/mem_write are 0 outside their states and never overlap.
- Req dropped mid-transaction: the transaction still completes and acks.
- Reset mid-transaction: immediate abort. If asserted before the WRITE edge, no memory write is committed.

Optional Feature:
- DMEM_ADDR_CHECK_EN defined:
  - In IDLE, a granted address >= DEPTH goes directly to DONE, with no mem_* strobes.
  - The owner's err=1 with its ack; rdata=0; txn_count still increments.
  - In-range accesses: err=0.
- Not defined: no check; err outputs are tied 0; every address is passed through unchanged.

Test Plan:
- Reset, then CPU read addr 5 with mem_rdata=5 -> mem_read high for 1 cycle; cpu_ack 2 cycles after sampling; cpu_rdata=5; txn_count=1.
- CPU write addr 10 data 0xDEADBEEF -> mem_write_en 1 cycle, then mem_write 1 cycle with addr 10/data 0xDEADBEEF; ack 3 cycles after sampling; a following DBG read of 10 returns 0xDEADBEEF.
- cpu_req and dbg_req both held high for 4 reads -> grants alternate CPU, DBG, CPU, DBG; each ack is a single cycle; txn_count=4.
- Rst pulsed low during ARM of a write to addr 20 -> all outputs 0 immediately; mem_write never asserts; memory word 20 unchanged.
- With DMEM_ADDR_CHECK_EN: DBG read addr 128 -> dbg_ack with dbg_err=1, dbg_rdata=0, no mem_read pulse. Without the macro: the same request produces a mem_read pulse and err=0.
- txn_count preset near wrap (CNT_W=4, 15 transactions) then one more -> txn_count=0.
